// File: rtl/power_seq_pkg.sv
// Shared state encoding for the oscillator power sequencer.
// Status decoders and benches import it so the codes stay in step with the FSM.
package power_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_WARMUP = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam int unsigned CNT_W = 16;

  function automatic logic is_powered(input state_t s);
    return (s == ST_WARMUP) || (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Saturating cycle counter: clears on request, otherwise counts up and holds at all-ones.
module seq_counter
  import power_seq_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/power_sequencer.sv
// Oscillator power sequencer: powers up, waits for a valid oscillator, releases the
// clock, and on shutdown gates the clock off for a drain period before removing power.
module power_sequencer
  import power_seq_pkg::*;
#(
  parameter int unsigned WARMUP_CYCLES  = 100,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned DRAIN_CYCLES   = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       on_req,
  input  logic       off_req,
  input  logic       osc_valid,
  input  logic       fault_clr,
  output logic       power,
  output logic       clk_en,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   count;

  // Any state change is a state entry, so the counter restarts from zero in the new state.
  seq_counter #(
    .WIDTH(CNT_W)
  ) u_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state_d != state_q),
    .enable  (1'b1),
    .count   (count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (on_req && !off_req) state_d = ST_WARMUP;
      end
      ST_WARMUP: begin
        if (off_req)                                  state_d = ST_OFF;
        else if ((count >= WARM_LAST) && osc_valid)   state_d = ST_RUN;
        else if ((count == TOUT_LAST) && !osc_valid)  state_d = ST_FAULT;
      end
      ST_RUN: begin
        if (off_req)         state_d = ST_DRAIN;
        else if (!osc_valid) state_d = ST_FAULT;
      end
      ST_DRAIN: begin
        if (count == DRAIN_LAST) state_d = ST_OFF;
      end
      ST_FAULT: begin
        if (fault_clr) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_OFF;
      power   <= 1'b0;
      clk_en  <= 1'b0;
      ready   <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      power   <= is_powered(state_d);
      clk_en  <= (state_d == ST_RUN);
      ready   <= (state_d == ST_RUN);
      fault   <= (state_d == ST_FAULT);
    end
  end

  assign state = 3'(state_q);

endmodule

// File: tb/tb_power_sequencer.sv
// Directed scoreboard bench for power_sequencer (WARMUP=4, TIMEOUT=10, DRAIN=2).
// Stimulus queues timed expectations; a free-running monitor samples and compares them.
module tb_power_sequencer;
  import power_seq_pkg::*;

  logic       clock;
  logic       reset_n;
  logic       on_req;
  logic       off_req;
  logic       osc_valid;
  logic       fault_clr;
  logic       power;
  logic       clk_en;
  logic       ready;
  logic       fault;
  logic [2:0] state;

  power_sequencer #(
    .WARMUP_CYCLES  (4),
    .TIMEOUT_CYCLES (10),
    .DRAIN_CYCLES   (2)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .on_req    (on_req),
    .off_req   (off_req),
    .osc_valid (osc_valid),
    .fault_clr (fault_clr),
    .power     (power),
    .clk_en    (clk_en),
    .ready     (ready),
    .fault     (fault),
    .state     (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    time        t;
    string      name;
    logic [6:0] exp;
    logic [6:0] mask;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  bit   stim_done = 1'b0;

  // Expected {state, power, clk_en, ready, fault} for each legal state.
  function automatic logic [6:0] exp_vec(input state_t s);
    case (s)
      ST_OFF:    return 7'b000_0000;
      ST_WARMUP: return 7'b001_1000;
      ST_RUN:    return 7'b010_1110;
      ST_DRAIN:  return 7'b011_1000;
      ST_FAULT:  return 7'b100_0001;
      default:   return 7'b111_1111;
    endcase
  endfunction

  function automatic void push(input time t, input string name,
                               input logic [6:0] e, input logic [6:0] m);
    exp_t x;
    x.t    = t;
    x.name = name;
    x.exp  = e;
    x.mask = m;
    sb.push_back(x);
  endfunction

  // Drive one cycle of inputs at the falling edge; expect the result after the next rise.
  task automatic tick(input logic on, input logic off, input logic osc, input logic clr,
                      input string name, input state_t s);
    @(negedge clock);
    on_req    = on;
    off_req   = off;
    osc_valid = osc;
    fault_clr = clr;
    push($time + 8, name, exp_vec(s), 7'h7f);
  endtask

  task automatic to_run(input string tag);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, {tag, "_warm"}, ST_WARMUP);
    tick(1'b1, 1'b0, 1'b1, 1'b0, {tag, "_run"}, ST_RUN);
  endtask

  // Monitor: samples at 3 and 8 units into every 10-unit cycle (before and after the rise).
  initial begin
    exp_t       e;
    logic [6:0] act;
    #3;
    forever begin
      while (sb.size() > 0 && sb[0].t <= $time) begin
        e   = sb.pop_front();
        act = {state, power, clk_en, ready, fault};
        checks++;
        if (e.t != $time)
          $display("FAIL %s: sampled late at %0t, wanted at %0t", e.name, $time, e.t);
        else if (((act ^ e.exp) & e.mask) != 7'b0)
          $display("FAIL %s: got {state,pwr,clk_en,rdy,flt}=%b, want %b (mask %b)",
                   e.name, act, e.exp, e.mask);
        else
          passed++;
      end
      if (stim_done && sb.size() == 0) break;
      #5;
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    on_req    = 1'b0;
    off_req   = 1'b0;
    osc_valid = 1'b0;
    fault_clr = 1'b0;
    push(3, "reset_state", exp_vec(ST_OFF), 7'h7f);
    push(8, "reset_edge",  exp_vec(ST_OFF), 7'h7f);
    @(negedge clock);
    reset_n = 1'b1;
    push($time + 8, "release_idle", exp_vec(ST_OFF), 7'h7f);

    // Normal power-up: oscillator valid from cycle 2, RUN after edge 4.
    tick(1, 0, 0, 0, "pu_e0",     ST_WARMUP);
    tick(1, 0, 0, 0, "pu_e1",     ST_WARMUP);
    tick(1, 0, 1, 0, "pu_e2",     ST_WARMUP);
    tick(1, 0, 1, 0, "pu_e3",     ST_WARMUP);
    tick(1, 0, 1, 0, "pu_e4_run", ST_RUN);
    tick(0, 0, 1, 0, "run_hold",  ST_RUN);

    // Orderly shutdown: one-cycle off_req, two drain cycles, then OFF.
    tick(0, 1, 1, 0, "drain_0",   ST_DRAIN);
    tick(0, 0, 1, 0, "drain_1",   ST_DRAIN);
    tick(0, 0, 1, 0, "drain_off", ST_OFF);
    tick(0, 0, 0, 0, "off_idle",  ST_OFF);

    // Timeout: osc_valid never asserts, FAULT after edge 10.
    tick(1, 0, 0, 0, "to_e0", ST_WARMUP);
    for (int i = 1; i <= 9; i++) tick(1, 0, 0, 0, "to_wait", ST_WARMUP);
    tick(1, 0, 0, 0, "to_e10_fault", ST_FAULT);
    tick(1, 0, 0, 0, "fault_sticky", ST_FAULT);
    tick(1, 0, 0, 1, "fault_clr",    ST_OFF);
    tick(1, 0, 0, 0, "rearm_warmup", ST_WARMUP);
    tick(1, 1, 0, 0, "warmup_abort", ST_OFF);
    tick(0, 0, 0, 0, "abort_idle",   ST_OFF);

    // Oscillator loss in RUN, then off_req priority over loss.
    to_run("loss");
    tick(1, 0, 0, 0, "osc_loss", ST_FAULT);
    tick(0, 0, 0, 1, "loss_clr", ST_OFF);
    to_run("prio");
    tick(1, 1, 0, 0, "prio_drain",   ST_DRAIN);
    tick(1, 0, 0, 0, "drain_ignore", ST_DRAIN);
    tick(1, 0, 0, 0, "drain_exit",   ST_OFF);
    tick(1, 0, 0, 0, "off_rearm",    ST_WARMUP);
    tick(1, 0, 0, 0, "warm_more",    ST_WARMUP);

    // Asynchronous reset mid-WARMUP with on_req held: OFF before the edge, WARMUP after.
    @(negedge clock);
    on_req = 1'b1; off_req = 1'b0; osc_valid = 1'b0; fault_clr = 1'b0;
    push($time + 3, "rst_async", exp_vec(ST_OFF),    7'h7f);
    push($time + 8, "rst_rearm", exp_vec(ST_WARMUP), 7'h7f);
    #1 reset_n = 1'b0;
    #3 reset_n = 1'b1;
    tick(0, 0, 0, 0, "warm_after_rst", ST_WARMUP);

    // Reset without on_req: stays OFF after release.
    @(negedge clock);
    on_req = 1'b0;
    push($time + 3, "rst_async2",   exp_vec(ST_OFF), 7'h7f);
    push($time + 8, "rst_stay_off", exp_vec(ST_OFF), 7'h7f);
    #1 reset_n = 1'b0;
    #3 reset_n = 1'b1;
    tick(0, 0, 0, 0, "rst_idle", ST_OFF);

    // Illegal code 7 from RUN: outputs clear on the next edge, state settles to OFF.
    to_run("ill");
    @(negedge clock);
    on_req = 1'b0; osc_valid = 1'b1;
    force dut.state_q = state_t'(3'd7);
    push($time + 3, "illegal_code", 7'b111_1110, 7'h7f);
    push($time + 8, "illegal_outs", 7'b000_0000, 7'b000_1111);
    @(negedge clock);
    release dut.state_q;
    push($time + 8, "illegal_off", exp_vec(ST_OFF), 7'h7f);

    stim_done = 1'b1;
    #40;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      $display("FAIL %s: expectation never sampled, want %b", e.name, e.exp);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
